usr_cnt: RTL and testbench



---
 rtl/usr_cnt.sv | 56 +++++
 tb/tb_usr_cnt.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/usr_cnt.sv
// rtl/usr_cnt.sv - W-bit universal register cell: hold, shift, rotate, load, up/down count
`timescale 1ns/1ps
`celldefine
module usr_cnt #(
    parameter int           W  = 8,
    parameter logic [W-1:0] RV = '0
) (
    input  logic         CK,
    input  logic         R,
    input  logic         CE,
    input  logic [2:0]   M,
    input  logic [W-1:0] D,
    input  logic         DSR,
    input  logic         DSL,
    output logic [W-1:0] Q,
    output logic         SOR,
    output logic         SOL,
    output logic         TC
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_UP   = 3'b110;
    localparam logic [2:0] M_DN   = 3'b111;

    // An unknown mode falls through to default and poisons Q on purpose.
    always_ff @(posedge CK) begin
        if (R) begin
            Q <= RV;
        end else if (CE) begin
            case (M)
                M_HOLD:  Q <= Q;
                M_SHR:   Q <= {DSR, Q[W-1:1]};
                M_SHL:   Q <= {Q[W-2:0], DSL};
                M_LOAD:  Q <= D;
                M_ROR:   Q <= {Q[0], Q[W-1:1]};
                M_ROL:   Q <= {Q[W-2:0], Q[W-1]};
                M_UP:    Q <= Q + W'(1);
                M_DN:    Q <= Q - W'(1);
                default: Q <= {W{1'bx}};
            endcase
        end
    end

    assign SOR = Q[0];
    assign SOL = Q[W-1];

    // Held low while R is asserted so a resetting stage never enables the next one.
    assign TC = !R && CE && (((M == M_UP) && (&Q)) || ((M == M_DN) && (Q == '0)));

endmodule
`endcelldefine

// File: tb/tb_usr_cnt.sv
// tb/tb_usr_cnt.sv - self-checking bench for usr_cnt
`timescale 1ns/1ps
module tb_usr_cnt;

    logic       CK = 1'b0;
    logic       R = 1'b0;
    logic       CE = 1'b0;
    logic [2:0] M = 3'b000;
    logic [7:0] D = 8'h00;
    logic       DSR = 1'b0;
    logic       DSL = 1'b0;
    logic [7:0] Q;
    logic       SOR, SOL, TC;

    logic       cas_load = 1'b0;
    logic       cas_run = 1'b0;
    logic [3:0] lo_q, hi_q;
    logic       lo_sor, lo_sol, lo_tc, hi_sor, hi_sol, hi_tc;
    logic       lo_ce, hi_ce;
    logic [2:0] cas_m;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq;
    logic       tc_obs;

    always #5 CK = ~CK;

    usr_cnt #(.W(8), .RV(8'hA5)) dut (
        .CK(CK), .R(R), .CE(CE), .M(M), .D(D), .DSR(DSR), .DSL(DSL),
        .Q(Q), .SOR(SOR), .SOL(SOL), .TC(TC)
    );

    assign lo_ce = cas_load | cas_run;
    assign hi_ce = cas_load ? 1'b1 : (cas_run & lo_tc);
    assign cas_m = cas_load ? 3'b011 : 3'b110;

    usr_cnt #(.W(4)) u_lo (
        .CK(CK), .R(R), .CE(lo_ce), .M(cas_m), .D(4'hE), .DSR(1'b0), .DSL(1'b0),
        .Q(lo_q), .SOR(lo_sor), .SOL(lo_sol), .TC(lo_tc)
    );

    usr_cnt #(.W(4)) u_hi (
        .CK(CK), .R(R), .CE(hi_ce), .M(cas_m), .D(4'h0), .DSR(1'b0), .DSL(1'b0),
        .Q(hi_q), .SOR(hi_sor), .SOL(hi_sol), .TC(hi_tc)
    );

    function automatic logic [7:0] ref_next(input logic [7:0] q, input logic r, input logic ce,
                                            input logic [2:0] m, input logic [7:0] d,
                                            input logic dsr, input logic dsl);
        int v;
        if (r) return 8'hA5;
        if (!ce) return q;
        v = int'(q);
        case (m)
            3'd0: return q;
            3'd1: return 8'((v / 2) + (dsr ? 128 : 0));
            3'd2: return 8'(((v * 2) % 256) + (dsl ? 1 : 0));
            3'd3: return d;
            3'd4: return 8'((v / 2) + ((v % 2) * 128));
            3'd5: return 8'(((v * 2) % 256) + (v / 128));
            3'd6: return 8'((v + 1) % 256);
            default: return 8'((v + 255) % 256);
        endcase
    endfunction

    function automatic logic ref_tc(input logic [7:0] q, input logic r, input logic ce,
                                    input logic [2:0] m);
        if (r || !ce) return 1'b0;
        if (m == 3'd6 && q == 8'd255) return 1'b1;
        if (m == 3'd7 && q == 8'd0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r_i, input logic ce_i, input logic [2:0] m_i,
                        input logic [7:0] d_i, input logic dsr_i, input logic dsl_i);
        logic [7:0] nq;
        @(negedge CK);
        R = r_i; CE = ce_i; M = m_i; D = d_i; DSR = dsr_i; DSL = dsl_i;
        #1;
        tc_obs = TC;
        chk("tc", 64'(TC), 64'(ref_tc(mq, r_i, ce_i, m_i)));
        nq = ref_next(mq, r_i, ce_i, m_i, d_i, dsr_i, dsl_i);
        @(posedge CK);
        #1;
        mq = nq;
        chk("q", 64'(Q), 64'(mq));
        chk("sor", 64'(SOR), 64'(mq[0]));
        chk("sol", 64'(SOL), 64'(mq[7]));
    endtask

    initial begin
        mq = 8'hxx;
        tc_obs = 1'b0;

        // reset and hold
        step(1, 1, 3'b110, 8'h00, 0, 0);
        chk("rst_tc", 64'(tc_obs), 64'(0));
        chk("rst_q", 64'(Q), 64'(8'hA5));
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 3'b000, 8'hFF, 1, 1);
            chk("hold_q", 64'(Q), 64'(8'hA5));
            chk("hold_so", 64'({SOR, SOL}), 64'(2'b11));
            chk("hold_tc", 64'(TC), 64'(0));
        end

        // load and shift right
        step(0, 1, 3'b011, 8'h81, 1, 1);
        chk("load_q", 64'(Q), 64'(8'h81));
        chk("load_sor", 64'(SOR), 64'(1));
        step(0, 1, 3'b001, 8'h00, 0, 1);
        chk("shr1_q", 64'(Q), 64'(8'h40));
        chk("shr1_sor", 64'(SOR), 64'(0));
        step(0, 1, 3'b001, 8'h00, 0, 1);
        chk("shr2_q", 64'(Q), 64'(8'h20));

        // shift left and rotates
        step(0, 1, 3'b011, 8'h81, 0, 0);
        step(0, 1, 3'b010, 8'h55, 0, 1);
        chk("shl_q", 64'(Q), 64'(8'h03));
        step(0, 1, 3'b101, 8'h55, 1, 0);
        chk("rol_q", 64'(Q), 64'(8'h06));
        step(0, 1, 3'b100, 8'h55, 1, 1);
        chk("ror1_q", 64'(Q), 64'(8'h03));
        step(0, 1, 3'b100, 8'h55, 0, 0);
        chk("ror2_q", 64'(Q), 64'(8'h81));

        // count wrap and terminal count
        step(0, 1, 3'b011, 8'hFE, 0, 0);
        step(0, 1, 3'b110, 8'h00, 0, 0);
        chk("up_ff_q", 64'(Q), 64'(8'hFF));
        #1 chk("up_ff_tc", 64'(TC), 64'(1));
        step(0, 1, 3'b110, 8'h00, 0, 0);
        chk("up_wrap_q", 64'(Q), 64'(8'h00));
        chk("up_wrap_tc", 64'(TC), 64'(0));
        step(0, 1, 3'b111, 8'h00, 0, 0);
        chk("dn_tc", 64'(tc_obs), 64'(1));
        chk("dn_wrap_q", 64'(Q), 64'(8'hFF));

        // enable and reset priority
        step(0, 1, 3'b011, 8'hFF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 3'b110, 8'h12, 1, 1);
            chk("ce0_q", 64'(Q), 64'(8'hFF));
            chk("ce0_tc", 64'(tc_obs), 64'(0));
        end
        step(1, 1, 3'b011, 8'h3C, 0, 0);
        chk("rst_pri_q", 64'(Q), 64'(8'hA5));

        // randomized run against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [7:0] dv;
            case ($urandom_range(0, 3))
                0: dv = 8'h00;
                1: dv = 8'hFF;
                default: dv = 8'($urandom);
            endcase
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                 3'($urandom), dv, 1'($urandom), 1'($urandom));
        end

        // two-stage cascade
        @(negedge CK);
        R = 1'b0; CE = 1'b0; cas_load = 1'b1;
        @(posedge CK); #1;
        chk("cas_load", 64'({hi_q, lo_q}), 64'(8'h0E));
        @(negedge CK);
        cas_load = 1'b0; cas_run = 1'b1;
        @(posedge CK); #1;
        chk("cas_0f", 64'({hi_q, lo_q}), 64'(8'h0F));
        chk("cas_lo_tc", 64'(lo_tc), 64'(1));
        @(posedge CK); #1;
        chk("cas_10", 64'({hi_q, lo_q}), 64'(8'h10));
        @(posedge CK); #1;
        chk("cas_11", 64'({hi_q, lo_q}), 64'(8'h11));
        chk("cas_so", 64'({hi_sol, hi_sor, lo_sol, lo_sor}), 64'(4'b0101));
        chk("cas_hi_tc", 64'(hi_tc), 64'(0));
        @(negedge CK);
        cas_run = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
